// File: rtl/spw_rx_char_fifo.sv
// SpaceWire receive character FIFO feeding the CPU 9-bit input port.
// Define SPW_RX_DROP_EN to drop characters when full instead of stalling.
module spw_rx_char_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [8:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  pop_req,
    input  logic                  clr_ovf,
    output logic [8:0]            data_o,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   C_DEPTH   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);

    logic [8:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_pop_d;

    logic [8:0]            r_data_o;
    logic                  r_empty;
    logic                  r_full;
    logic [DEPTH_LOG2:0]   r_level;

    logic                  w_full_int;
    logic                  w_empty_int;
    logic                  w_pop_ev;
    logic                  w_pop;
    logic                  w_push;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_full_int  = (r_count == C_DEPTH);
    assign w_empty_int = (r_count == '0);
    assign w_pop_ev    = pop_req & ~r_pop_d;
    assign w_pop       = w_pop_ev & ~w_empty_int;

`ifdef SPW_RX_DROP_EN
    logic w_drop;
    logic r_ovf;

    // A pop on the same edge frees a slot, so only a truly full FIFO drops.
    assign rx_ready = 1'b1;
    assign w_push   = rx_valid & (~w_full_int | w_pop);
    assign w_drop   = rx_valid & w_full_int & ~w_pop;
    assign overflow = r_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end
`else
    logic w_unused;

    assign rx_ready = ~w_full_int;
    assign w_push   = rx_valid & ~w_full_int;
    assign overflow = 1'b0;
    assign w_unused = clr_ovf;
`endif

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pop_d  <= 1'b0;
        end else begin
            r_pop_d <= pop_req;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Output port registers mirror the settled internal state one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_o <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_level  <= '0;
        end else begin
            r_data_o <= w_empty_int ? 9'h000 : r_mem[r_rd_ptr];
            r_empty  <= w_empty_int;
            r_full   <= w_full_int;
            r_level  <= r_count;
        end
    end

    assign data_o = r_data_o;
    assign empty  = r_empty;
    assign full   = r_full;
    assign level  = r_level;

endmodule

// File: tb/tb_spw_rx_char_fifo.sv
// Randomized self-checking bench for spw_rx_char_fifo against a queue model.
// Drop-mode scenario is compiled in when SPW_RX_DROP_EN is defined.
module tb_spw_rx_char_fifo;

    localparam int DL2 = 4;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           rx_valid;
    logic [8:0]     rx_data;
    logic           rx_ready;
    logic           pop_req;
    logic           clr_ovf;
    logic [8:0]     data_o;
    logic           empty;
    logic           full;
    logic [DL2:0]   level;
    logic           overflow;

    spw_rx_char_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .pop_req  (pop_req),
        .clr_ovf  (clr_ovf),
        .data_o   (data_o),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [8:0] q[$];
    logic       m_pop_d = 1'b0;
    logic       m_ovf = 1'b0;
`ifdef SPW_RX_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    int         exp_level;
    logic [8:0] exp_head;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ready;
    logic       obs_ready;

    // One clock of stimulus; model outputs lag the stored state by one edge.
    task automatic drive(input logic v, input logic [8:0] d,
                         input logic p, input logic c);
        int  sz;
        bit  pop_ev;
        bit  push;
        bit  drop;
        rx_valid = v;
        rx_data  = d;
        pop_req  = p;
        clr_ovf  = c;
        sz = q.size();
        exp_ready = DROP ? 1'b1 : (sz < DEPTH);
        pop_ev = p && !m_pop_d && sz > 0;
        push = v && (DROP ? (sz < DEPTH || pop_ev) : (sz < DEPTH));
        drop = DROP && v && !push;
        exp_level = sz;
        exp_head  = (sz > 0) ? q[0] : 9'h000;
        exp_empty = (sz == 0);
        exp_full  = (sz == DEPTH);
        #1 obs_ready = rx_ready;
        @(posedge clk);
        #1;
        if (pop_ev) void'(q.pop_front());
        if (push) q.push_back(d);
        m_pop_d = p;
        if (drop) m_ovf = 1'b1;
        else if (c && DROP) m_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        pop_req = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (empty !== 1'b1 || level !== 0 || data_o !== 9'h000 ||
            full !== 1'b0 || overflow !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: empty=%b level=%0d data=%h full=%b ovf=%b rdy=%b",
                     empty, level, data_o, full, overflow, rx_ready);
        end
        reset_n = 1'b1;
        q.delete();
        m_pop_d = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic test_basic;
        drive(1'b1, 9'h041, 1'b0, 1'b0);
        drive(1'b1, 9'h042, 1'b0, 1'b0);
        drive(1'b1, 9'h100, 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (level !== 3 || empty !== 1'b0 || data_o !== 9'h041) begin
            failures++;
            $display("FAIL basic_push: level=%0d empty=%b data=%h want 3 0 041",
                     level, empty, data_o);
        end
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (data_o !== 9'h042) begin
            failures++;
            $display("FAIL basic_pop1: data=%h want 042", data_o);
        end
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (data_o !== 9'h100) begin
            failures++;
            $display("FAIL basic_pop2: data=%h want 100", data_o);
        end
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (data_o !== 9'h000 || empty !== 1'b1) begin
            failures++;
            $display("FAIL basic_pop3: data=%h empty=%b want 000 1",
                     data_o, empty);
        end
    endtask

    task automatic test_fill;
        logic [8:0] last;
        last = 9'h000;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 9'(i), 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || level !== 16 ||
            (!DROP && rx_ready !== 1'b0)) begin
            failures++;
            $display("FAIL fill: full=%b level=%0d rdy=%b want 1 16 0",
                     full, level, rx_ready);
        end
        if (!DROP) begin
            for (int i = 0; i < 3; i++) drive(1'b1, 9'h0AA, 1'b0, 1'b0);
            checks++;
            if (level !== 16 || obs_ready !== 1'b0) begin
                failures++;
                $display("FAIL fill_hold: level=%0d rdy=%b want 16 0",
                         level, obs_ready);
            end
            drive(1'b1, 9'h0AA, 1'b1, 1'b0);
            drive(1'b1, 9'h0AA, 1'b0, 1'b0);
            drive(1'b0, 9'h000, 1'b0, 1'b0);
            drive(1'b0, 9'h000, 1'b0, 1'b0);
            checks++;
            if (level !== 16 || data_o !== 9'h001) begin
                failures++;
                $display("FAIL fill_refill: level=%0d data=%h want 16 001",
                         level, data_o);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (data_o !== exp_head) begin
                failures++;
                $display("FAIL fill_drain: data=%h want %h", data_o, exp_head);
            end
            last = data_o;
            drive(1'b0, 9'h000, 1'b1, 1'b0);
            drive(1'b0, 9'h000, 1'b0, 1'b0);
        end
        if (!DROP) begin
            checks++;
            if (last !== 9'h0AA || empty !== 1'b1) begin
                failures++;
                $display("FAIL fill_last: last=%h empty=%b want 0AA 1",
                         last, empty);
            end
        end
    endtask

    task automatic test_pop_empty;
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (level !== 0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL pop_empty: level=%0d empty=%b want 0 1", level, empty);
        end
        drive(1'b1, 9'h055, 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (data_o !== 9'h055 || level !== 1) begin
            failures++;
            $display("FAIL pop_empty_push: data=%h level=%0d want 055 1",
                     data_o, level);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 9'h077, 1'b1, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (level !== 1 || data_o !== 9'h077) begin
            failures++;
            $display("FAIL same_edge: level=%0d data=%h want 1 077",
                     level, data_o);
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 9'($urandom_range(0, 511)), 1'b1, 1'b0);
            drive(1'b0, 9'h000, 1'b0, 1'b0);
            checks++;
            if (level !== exp_level || data_o !== exp_head) begin
                failures++;
                $display("FAIL wrap[%0d]: level=%0d data=%h want %0d %h",
                         i, level, data_o, exp_level, exp_head);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 55), 9'($urandom_range(0, 511)),
                  1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (level !== exp_level || data_o !== exp_head ||
                empty !== exp_empty || full !== exp_full ||
                obs_ready !== exp_ready || overflow !== m_ovf) begin
                failures++;
                $display("FAIL random[%0d]: lvl=%0d/%0d dat=%h/%h e=%b/%b f=%b/%b r=%b/%b o=%b/%b",
                         i, level, exp_level, data_o, exp_head, empty, exp_empty,
                         full, exp_full, obs_ready, exp_ready, overflow, m_ovf);
            end
        end
    endtask

`ifdef SPW_RX_DROP_EN
    task automatic test_drop;
        while (q.size() > 0) begin
            drive(1'b0, 9'h000, 1'b1, 1'b0);
            drive(1'b0, 9'h000, 1'b0, 1'b0);
        end
        drive(1'b0, 9'h000, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 9'(i + 3), 1'b0, 1'b0);
        drive(1'b1, 9'h1FF, 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || level !== 16 || data_o !== 9'h003) begin
            failures++;
            $display("FAIL drop: ovf=%b level=%0d data=%h want 1 16 003",
                     overflow, level, data_o);
        end
        drive(1'b0, 9'h000, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL drop_clr: ovf=%b want 0", overflow);
        end
        drive(1'b1, 9'h1FF, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL drop_set_wins: ovf=%b want 1", overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 9'h000, 1'b0, 1'b0);
            checks++;
            if (data_o !== 9'(i + 3)) begin
                failures++;
                $display("FAIL drop_contents[%0d]: data=%h want %h",
                         i, data_o, 9'(i + 3));
            end
            drive(1'b0, 9'h000, 1'b1, 1'b0);
        end
        drive(1'b0, 9'h000, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_reset_mid;
        while (q.size() > 0) begin
            drive(1'b0, 9'h000, 1'b1, 1'b0);
            drive(1'b0, 9'h000, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) drive(1'b1, 9'h120 + 9'(i), 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (level !== 5) begin
            failures++;
            $display("FAIL reset_mid_pre: level=%0d want 5", level);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || level !== 0 || data_o !== 9'h000 ||
            overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: empty=%b level=%0d data=%h ovf=%b",
                     empty, level, data_o, overflow);
        end
        q.delete();
        m_pop_d = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(1'b1, 9'h1A5, 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++;
        if (data_o !== 9'h1A5 || level !== 1) begin
            failures++;
            $display("FAIL reset_mid_push: data=%h level=%0d want 1A5 1",
                     data_o, level);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_pop_empty();
        test_back_to_back();
        test_random();
`ifdef SPW_RX_DROP_EN
        test_drop();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
